regfile_mp: RTL and testbench

Parametrised successor to the team's 8x16 single-port register file: one write port, two independent combinational read ports, and a per-register busy scoreboard for multi-cycle producers.
- Sits between the datapath's writeback mux and the ALU A/B operand inputs.
- The controller marks a destination register busy when a long operation issues.
- Operand reads report busy status so the FSM can stall.
- Adds an asynchronous reset and optional write-to-read bypass.

---
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a per-register busy scoreboard.
// One write port, two combinational read ports (A/B), and a busy bit per
// register that a long-latency producer sets via claim and clears on write.
// Optional bypass forwards same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] writenum,
  input  logic                  write,
  input  logic                  claim,
  input  logic [ADDR_WIDTH-1:0] claimnum,
  input  logic [ADDR_WIDTH-1:0] readnum_a,
  input  logic [ADDR_WIDTH-1:0] readnum_b,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic [NUM_REGS-1:0]   busy_vec
);

  localparam bit BYP_EN = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  logic hit_a;
  logic hit_b;

  // Next-state: write stores data and retires the producer; a claim on the
  // same edge is applied last so the new producer supersedes the write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (write) begin
      regs_d[writenum] = data_in;
      busy_d[writenum] = 1'b0;
    end
    if (claim) begin
      busy_d[claimnum] = 1'b1;
    end
  end

  // State registers; async reset clears data and drops all pending claims.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports; bypass is gated by reset_n so outputs stay zero in reset.
  always_comb begin
    hit_a = BYP_EN && reset_n && write && (writenum == readnum_a);
    hit_b = BYP_EN && reset_n && write && (writenum == readnum_b);

    data_out_a = regs_q[readnum_a];
    busy_a     = busy_q[readnum_a];
    if (hit_a) begin
      data_out_a = data_in;
      busy_a     = claim && (claimnum == readnum_a);
    end

    data_out_b = regs_q[readnum_b];
    busy_b     = busy_q[readnum_b];
    if (hit_b) begin
      data_out_b = data_in;
      busy_b     = claim && (claimnum == readnum_b);
    end

    busy_vec = busy_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: default build, bypass build, and a
// 16x32 build used for the address/data sweep.
module tb_regfile_mp;

  logic        clk;
  logic        reset_n;

  // Shared stimulus for the 8x16 instances (no-bypass u0, bypass u1)
  logic [15:0] data_in;
  logic [2:0]  writenum, claimnum, readnum_a, readnum_b;
  logic        write, claim;

  logic [15:0] d0a, d0b, d1a, d1b;
  logic        b0a, b0b, b1a, b1b;
  logic [7:0]  bv0, bv1;

  // Stimulus for the 16x32 instance
  logic [31:0] w_data_in;
  logic [3:0]  w_writenum, w_claimnum, w_readnum_a, w_readnum_b;
  logic        w_write, w_claim;
  logic [31:0] w_da, w_db;
  logic        w_ba, w_bb;
  logic [15:0] w_bv;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.DATA_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3), .BYPASS(0)) u0 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum),
    .write(write), .claim(claim), .claimnum(claimnum),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(d0a), .data_out_b(d0b), .busy_a(b0a), .busy_b(b0b),
    .busy_vec(bv0)
  );

  regfile_mp #(.DATA_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3), .BYPASS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum),
    .write(write), .claim(claim), .claimnum(claimnum),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(d1a), .data_out_b(d1b), .busy_a(b1a), .busy_b(b1b),
    .busy_vec(bv1)
  );

  regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(4), .BYPASS(0)) u2 (
    .clk(clk), .reset_n(reset_n), .data_in(w_data_in), .writenum(w_writenum),
    .write(w_write), .claim(w_claim), .claimnum(w_claimnum),
    .readnum_a(w_readnum_a), .readnum_b(w_readnum_b),
    .data_out_a(w_da), .data_out_b(w_db), .busy_a(w_ba), .busy_b(w_bb),
    .busy_vec(w_bv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write on the 8x16 instances, inputs changed at negedge
  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    write = 1'b1; writenum = idx; data_in = val;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic cl(input logic [2:0] idx);
    @(negedge clk);
    claim = 1'b1; claimnum = idx;
    @(posedge clk); #1;
    claim = 1'b0;
  endtask

  task automatic test_reset;
    // state at time zero, reset held low
    #1;
    checks++;
    if (d0a !== 16'h0000 || bv0 !== 8'h00 || b0a !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: data_out_a=%h busy_vec=%h busy_a=%b, want 0000/00/0", d0a, bv0, b0a);
    end
    @(negedge clk); reset_n = 1'b1;
    wr(3'd3, 16'hBEEF);
    cl(3'd5);
    readnum_a = 3'd3; readnum_b = 3'd5;
    #1;
    checks++;
    if (d0a !== 16'hBEEF || bv0 !== 8'h20 || b0b !== 1'b1) begin
      errors++;
      $display("FAIL reset_prewrite: data_out_a=%h busy_vec=%h busy_b=%b, want BEEF/20/1", d0a, bv0, b0b);
    end
    // assert reset between edges; effect must be immediate
    #2; reset_n = 1'b0; #1;
    checks++;
    if (d0a !== 16'h0000 || bv0 !== 8'h00 || b0b !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: data_out_a=%h busy_vec=%h busy_b=%b, want 0000/00/0", d0a, bv0, b0b);
    end
    // writes and claims ignored while reset low, bypass suppressed too
    write = 1'b1; writenum = 3'd3; data_in = 16'h1111; claim = 1'b1; claimnum = 3'd3;
    #1;
    checks++;
    if (d1a !== 16'h0000 || b1a !== 1'b0) begin
      errors++;
      $display("FAIL reset_bypass_gated: data_out_a=%h busy_a=%b, want 0000/0", d1a, b1a);
    end
    @(posedge clk); #1;
    write = 1'b0; claim = 1'b0;
    checks++;
    if (d0a !== 16'h0000 || bv0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_ignore_write: data_out_a=%h busy_vec=%h, want 0000/00", d0a, bv0);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_dual_read;
    wr(3'd1, 16'h1234);
    wr(3'd6, 16'hABCD);
    readnum_a = 3'd1; readnum_b = 3'd6; #1;
    checks++;
    if (d0a !== 16'h1234 || d0b !== 16'hABCD) begin
      errors++;
      $display("FAIL dual_read: a=%h b=%h, want 1234/ABCD", d0a, d0b);
    end
    readnum_a = 3'd6; #1;
    checks++;
    if (d0a !== 16'hABCD || d0b !== 16'hABCD) begin
      errors++;
      $display("FAIL dual_same: a=%h b=%h, want ABCD/ABCD", d0a, d0b);
    end
  endtask

  task automatic test_write_latency;
    wr(3'd2, 16'h0005);
    @(negedge clk);
    write = 1'b1; writenum = 3'd2; data_in = 16'h00FF; readnum_a = 3'd2; readnum_b = 3'd1;
    #1;
    checks++;
    if (d0a !== 16'h0005) begin
      errors++;
      $display("FAIL latency_nobypass_pre: a=%h, want 0005", d0a);
    end
    checks++;
    if (d1a !== 16'h00FF || b1a !== 1'b0 || d1b !== 16'h1234) begin
      errors++;
      $display("FAIL latency_bypass_pre: a=%h busy_a=%b b=%h, want 00FF/0/1234", d1a, b1a, d1b);
    end
    @(posedge clk); #1;
    write = 1'b0;
    checks++;
    if (d0a !== 16'h00FF || d1a !== 16'h00FF) begin
      errors++;
      $display("FAIL latency_post: u0 a=%h u1 a=%h, want 00FF/00FF", d0a, d1a);
    end
    // bypassed busy with a same-index claim in the same cycle
    @(negedge clk);
    write = 1'b1; claim = 1'b1; writenum = 3'd2; claimnum = 3'd2; data_in = 16'h0A0A;
    #1;
    checks++;
    if (b1a !== 1'b1 || b0a !== 1'b0 || bv1 !== 8'h00) begin
      errors++;
      $display("FAIL bypass_busy_claim: u1 busy_a=%b u0 busy_a=%b u1 busy_vec=%h, want 1/0/00", b1a, b0a, bv1);
    end
    @(posedge clk); #1;
    write = 1'b0; claim = 1'b0;
    wr(3'd2, 16'h0A0A);
  endtask

  task automatic test_scoreboard;
    readnum_a = 3'd4;
    cl(3'd4);
    checks++;
    if (bv0 !== 8'h10 || b0a !== 1'b1) begin
      errors++;
      $display("FAIL claim: busy_vec=%h busy_a=%b, want 10/1", bv0, b0a);
    end
    cl(3'd4);
    checks++;
    if (bv0 !== 8'h10) begin
      errors++;
      $display("FAIL claim_again: busy_vec=%h, want 10", bv0);
    end
    wr(3'd4, 16'h0042);
    checks++;
    if (bv0 !== 8'h00 || d0a !== 16'h0042 || b0a !== 1'b0) begin
      errors++;
      $display("FAIL write_clears: busy_vec=%h a=%h busy_a=%b, want 00/0042/0", bv0, d0a, b0a);
    end
  endtask

  task automatic test_collision;
    readnum_a = 3'd7;
    @(negedge clk);
    write = 1'b1; claim = 1'b1; writenum = 3'd7; claimnum = 3'd7; data_in = 16'h7777;
    @(posedge clk); #1;
    write = 1'b0; claim = 1'b0;
    checks++;
    if (d0a !== 16'h7777 || bv0 !== 8'h80) begin
      errors++;
      $display("FAIL collide_same: a=%h busy_vec=%h, want 7777/80", d0a, bv0);
    end
    @(negedge clk);
    write = 1'b1; claim = 1'b1; writenum = 3'd7; claimnum = 3'd0; data_in = 16'h1357;
    @(posedge clk); #1;
    write = 1'b0; claim = 1'b0;
    checks++;
    if (d0a !== 16'h1357 || bv0 !== 8'h01) begin
      errors++;
      $display("FAIL collide_diff: a=%h busy_vec=%h, want 1357/01", d0a, bv0);
    end
    // mid-operation reset drops the pending claim on reg0
    #2; reset_n = 1'b0; #1;
    checks++;
    if (bv0 !== 8'h00 || d0a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_midop: busy_vec=%h a=%h, want 00/0000", bv0, d0a);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      w_write = 1'b1; w_writenum = 4'(i); w_data_in = 32'(i) * 32'h01010101;
      @(posedge clk); #1;
    end
    w_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_readnum_a = 4'(i); w_readnum_b = 4'(15 - i); #1;
      checks++;
      if (w_da !== 32'(i) * 32'h01010101 || w_db !== 32'(15 - i) * 32'h01010101) begin
        errors++;
        $display("FAIL sweep[%0d]: a=%h b=%h, want %h/%h", i, w_da, w_db,
                 32'(i) * 32'h01010101, 32'(15 - i) * 32'h01010101);
      end
    end
    checks++;
    if (w_bv !== 16'h0000 || w_ba !== 1'b0 || w_bb !== 1'b0) begin
      errors++;
      $display("FAIL sweep_busy: busy_vec=%h, want 0000", w_bv);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    data_in = '0; writenum = '0; claimnum = '0; readnum_a = '0; readnum_b = '0;
    write = 1'b0; claim = 1'b0;
    w_data_in = '0; w_writenum = '0; w_claimnum = '0; w_readnum_a = '0; w_readnum_b = '0;
    w_write = 1'b0; w_claim = 1'b0;
    test_reset();
    test_dual_read();
    test_write_latency();
    test_scoreboard();
    test_collision();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
